// File: rtl/ula_exec.sv
// ULA execution stage: one-cycle logic/arithmetic, iterative one-bit-per-cycle shifts.
// Define ULA_EXEC_BARREL_EN to compute shifts in one cycle with a combinational barrel shifter.
module ula_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifndef ULA_EXEC_BARREL_EN
  localparam logic [1:0] S_SHIFT = 2'd1;
`endif
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_err;
  logic             w_shift;

  always_comb begin
    w_sum   = A + B;
    w_diff  = A - B;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    w_shift = 1'b0;
    case (OP)
      4'b0000: w_res = A & B;
      4'b0001: w_res = A | B;
      4'b0011: w_res = A ^ B;
      4'b0100: w_res = ~(A | B);
      4'b0101: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0110: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1000: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001, 4'b1010, 4'b1011: begin
        w_shift = 1'b1;
`ifdef ULA_EXEC_BARREL_EN
        case (OP[1:0])
          2'b01:   w_res = B << Shamt;
          2'b10:   w_res = B >> Shamt;
          default: w_res = $unsigned($signed(B) >>> Shamt);
        endcase
`else
        // Only reached directly when Shamt is zero; otherwise the iterative path writes result.
        w_res = B;
`endif
      end
      // Unsupported codes, including X/Z, land here.
      default: w_err = 1'b1;
    endcase
  end

`ifndef ULA_EXEC_BARREL_EN
  logic [WIDTH-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic [1:0]       r_shop;
  logic [WIDTH-1:0] w_step;

  always_comb begin
    case (r_shop)
      2'b01:   w_step = {r_acc[WIDTH-2:0], 1'b0};
      2'b10:   w_step = {1'b0, r_acc[WIDTH-1:1]};
      default: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
`ifndef ULA_EXEC_BARREL_EN
      r_acc    <= '0;
      r_cnt    <= '0;
      r_shop   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifndef ULA_EXEC_BARREL_EN
            if (w_shift && (Shamt != 5'd0)) begin
              r_acc   <= B;
              r_cnt   <= Shamt;
              r_shop  <= OP[1:0];
              r_ovf   <= 1'b0;
              r_err   <= 1'b0;
              r_state <= S_SHIFT;
            end else
`endif
            begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_err    <= w_err;
              r_state  <= S_DONE;
            end
          end
        end
`ifndef ULA_EXEC_BARREL_EN
        S_SHIFT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_step;
            r_zero   <= (w_step == '0);
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign zero   = r_zero;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule

// File: tb/tb_ula_exec.sv
// Self-checking bench for ula_exec: directed scenarios plus randomized ops against a
// behavioural model.
module tb_ula_exec;

  localparam longint MaxS = 2147483647;
  localparam longint MinS = -MaxS - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  OP    = 4'd0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic [4:0]  Shamt = '0;
  logic        busy, done, zero, ovf, err;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  ula_exec #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .OP     (OP),
    .A      (A),
    .B      (B),
    .Shamt  (Shamt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .ovf    (ovf),
    .err    (err)
  );

  always #5 clock = ~clock;

  // Reference: result, overflow, error flag and cycles from acceptance to done.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output bit o,
                       output bit e, output int lat);
    longint s;
    r = '0; o = 0; e = 0; lat = 1;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = ~(a | b);
      4'd5: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r = s[31:0];
        o = (s > MaxS) || (s < MinS);
      end
      4'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        o = (s > MaxS) || (s < MinS);
      end
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9, 4'd10, 4'd11: begin
        if (op == 4'd9)       r = b << sh;
        else if (op == 4'd10) r = b >> sh;
        else                  r = $unsigned($signed(b) >>> sh);
`ifndef ULA_EXEC_BARREL_EN
        lat = int'(sh) + 1;
`endif
      end
      default: e = 1;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit noise, input string tag);
    logic [31:0] er;
    bit eo, ee, got;
    int el, cyc;
    model(op, a, b, sh, er, eo, ee, el);
    @(negedge clock);
    start = 1'b1; OP = op; A = a; B = b; Shamt = sh;
    @(posedge clock);
    #1;
    start = 1'b0; OP = 4'($urandom); A = $urandom; B = $urandom; Shamt = 5'($urandom);
    cyc = 0; got = 0;
    while (!got && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (done === 1'b1) got = 1;
      else begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy: got %b want 1 (cycle %0d)", tag, busy, cyc);
        end
        if (noise) start = 1'($urandom);
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles, want %0d", tag, cyc, el);
    end else begin
      n_vec += 5;
      if (cyc != el) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, el);
      end
      if (result !== er) begin
        n_err++; $display("FAIL %s result: got %h want %h", tag, result, er);
      end
      if (zero !== (er == 32'd0)) begin
        n_err++; $display("FAIL %s zero: got %b want %b", tag, zero, (er == 32'd0));
      end
      if (ovf !== eo) begin
        n_err++; $display("FAIL %s ovf: got %b want %b", tag, ovf, eo);
      end
      if (err !== ee) begin
        n_err++; $display("FAIL %s err: got %b want %b", tag, err, ee);
      end
      if (noise) start = 1'b1;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after_done: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1 ||
        ovf !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b result=%h zero=%b ovf=%b err=%b want 0 0 0 1 0 0",
               tag, busy, done, result, zero, ovf, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int dones;
    run_op(4'd0, 32'hF0, 32'h3C, 5'd0, 0, "pre_reset_and");
    @(negedge clock);
    start = 1'b1; OP = 4'd9; A = 32'h0; B = 32'h1; Shamt = 5'd20;
    @(posedge clock);
    #1;
    start = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_vals("reset_mid_shift");
    @(negedge clock);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
`ifndef ULA_EXEC_BARREL_EN
    n_vec++;
    if (dones != 0) begin
      n_err++; $display("FAIL reset_mid_shift done_pulses: got %0d want 0", dones);
    end
`endif
    #1;
    check_reset_vals("reset_mid_shift_after");
  endtask

  task automatic test_add_ovf();
    run_op(4'd5, 32'h7FFFFFFF, 32'h1, 5'd0, 0, "add_ovf");
  endtask

  task automatic test_sub_cmp();
    run_op(4'd6, 32'h1234, 32'h1234, 5'd0, 0, "sub_zero");
    run_op(4'd8, 32'hFFFFFFFF, 32'h1, 5'd0, 0, "slt");
    run_op(4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 0, "sltu");
    run_op(4'd6, 32'h80000000, 32'h1, 5'd0, 0, "sub_ovf");
  endtask

  task automatic test_sra();
    run_op(4'd11, 32'h0, 32'h80000000, 5'd4, 1, "sra");
    run_op(4'd10, 32'h0, 32'h80000000, 5'd31, 1, "srl31");
  endtask

  task automatic test_zero_shift_unsupported();
    run_op(4'd9, 32'h0, 32'hA5, 5'd0, 0, "sll_zero");
    run_op(4'd15, 32'h5, 32'h6, 5'd3, 0, "op_1111");
    run_op(4'd2, 32'h5, 32'h6, 5'd3, 0, "op_0010");
  endtask

  task automatic test_back_to_back();
    bit exp;
    run_op(4'd1, 32'h1, 32'h2, 5'd0, 0, "pre_b2b_or");
    @(negedge clock);
    start = 1'b1; OP = 4'd0; A = 32'hF0; B = 32'h3C; Shamt = 5'd0;
    @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      exp = (i % 2 == 0);
      n_vec++;
      if (done !== exp) begin
        n_err++; $display("FAIL b2b done[%0d]: got %b want %b", i, done, exp);
      end
      if (exp) begin
        n_vec++;
        if (result !== 32'h30) begin
          n_err++; $display("FAIL b2b result[%0d]: got %h want 00000030", i, result);
        end
      end
      if (i == 19) start = 1'b0;
    end
    @(posedge clock);
  endtask

  task automatic test_random();
    logic [3:0] ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                              4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 13)];
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = a;
      run_op(op, a, b, 5'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_cmp();
    test_sra();
    test_zero_shift_unsupported();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_exec.md
# ula_exec

Sequential execution stage that consumes the 4-bit operation code produced by the ULA controller and computes the result for the processor datapath. Logic and arithmetic operations complete in one cycle. Shifts run iteratively, one bit per cycle, so a wide barrel shifter is not needed. The block sits between the ULA controller/register-file read stage and write-back, and uses a start/done handshake so the control unit can stall while it is busy.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: request a new operation. Sampled only in `IDLE`.
- `OP` input, 4 bits: operation code from the ULA controller.
- `A` input, `WIDTH` bits: operand rs.
- `B` input, `WIDTH` bits: operand rt. This is also the value shifted by shift operations.
- `Shamt` input, 5 bits: shift amount, selected upstream (shamt field or rs[4:0]).
- `busy` output, 1 bit: high whenever state ≠ `IDLE`.
- `done` output, 1 bit: one-cycle pulse; result is valid.
- `result` output, `WIDTH` bits: registered result.
- `zero` output, 1 bit: registered, equals (`result == 0`).
- `ovf` output, 1 bit: signed overflow on ADD/SUB. Valid with `done`.
- `err` output, 1 bit: unsupported `OP`. Valid with `done`.

## Operation
- Operation codes:
  - `0000` AND; `0001` OR; `0011` XOR; `0100` NOR.
  - `0101` ADD and `0110` SUB, both modulo 2^`WIDTH`.
  - `0111` SLTU (unsigned): result = 1 if A < B, else 0.
  - `1000` SLT (signed): result = 1 if A < B, else 0.
  - `1001` SLL, `1010` SRL, `1011` SRA: shift B by `Shamt`. SRA replicates B's MSB.
- `ovf`:
  - ADD: set when A and B have the same sign and the sum's sign differs.
  - SUB: set when A and B have different signs and the difference's sign differs from A.
  - `ovf` = 0 for all other ops. Result is still written; no trap.
- Unsupported codes (`0010`, `1100`–`1111`, any X/Z): result = 0, `err` = 1, normal `done` timing.
- State machine (`IDLE`, `SHIFT`, `DONE`):
  - `IDLE`, `start` = 1, non-shift op: load `result`/`zero`/`ovf`/`err`; go to `DONE`.
  - `IDLE`, `start` = 1, shift op: latch B into accumulator and `Shamt` into counter; `ovf` = `err` = 0.
    - Counter = 0: `result` = B; go to `DONE`.
    - Otherwise: go to `SHIFT`.
  - `SHIFT`: shift accumulator one position per cycle and decrement counter. When counter reaches 0, write accumulator to `result`, update `zero`, go to `DONE`.
  - `DONE`: `done` = 1 for exactly this cycle; go to `IDLE` unconditionally. `start` is ignored here.
- `start` during `SHIFT` or `DONE` is ignored (no queueing). Inputs are sampled only at the accepting edge; later input changes do not affect an operation in flight.
- `result`, `zero`, `ovf` and `err` hold their values until the next accepted operation.

## Timing
- Reset values: state `IDLE`, `busy` 0, `done` 0, `result` 0, `zero` 1, `ovf` 0, `err` 0.
- Non-shift latency: `start` accepted at edge N → `done` high in cycle N+1.
- Shift latency: `Shamt` + 1 cycles. Example: `Shamt` = 31 → `done` 32 cycles after acceptance.
- Minimum spacing between accepted operations: 2 cycles, since `DONE` always returns to `IDLE` first.
- `reset` asserted mid-operation aborts immediately: no `done` pulse, all outputs return to reset values.
- `busy` and `done` are registered state decodes; they are never combinational from `start`.

## Configuration
- `ULA_EXEC_BARREL_EN` defined: shifts are computed in one cycle by a combinational barrel shifter, with the same latency as other ops. The `SHIFT` state and counter are not synthesized.
- `ULA_EXEC_BARREL_EN` not defined (default): iterative shifting as described above.
- Results are identical in both builds; only shift latency differs.

## Test plan
- Reset mid-shift: start SLL with `Shamt` = 20, assert `reset` at cycle 5 → no `done` pulse, `result` = 0, `zero` = 1, `busy` = 0.
- ADD overflow: ADD, A = 0x7FFFFFFF, B = 1 → `done` at N+1, `result` = 0x80000000, `ovf` = 1, `zero` = 0.
- SUB to zero, then signed/unsigned compare:
  - SUB, A = B = 0x1234 → `result` = 0, `zero` = 1.
  - SLT, A = 0xFFFFFFFF, B = 1 → `result` = 1.
  - SLTU with the same operands → `result` = 0.
- SRA: B = 0x80000000, `Shamt` = 4 → `result` = 0xF8000000. `done` 5 cycles after acceptance (1 cycle with `ULA_EXEC_BARREL_EN`). `start` pulses during `busy` are ignored.
- Zero shift and unsupported op:
  - SLL with `Shamt` = 0, B = 0xA5 → `result` = 0xA5, latency 1.
  - OP = `1111` → `result` = 0, `err` = 1, `done` at N+1.
- Back-to-back: `start` held high continuously with AND (A = 0xF0, B = 0x3C) → `done` every 2nd cycle, `result` = 0x30.
